// File: rtl/qed_inst_filter_if.sv
// rtl/qed_inst_filter_if.sv - instruction presentation bus for qed_inst_filter
interface qed_inst_filter_if;
    logic        inst_valid;
    logic [31:0] instruction;
    logic        inst_legal;
    logic [11:0] inst_class;

    modport master (
        output inst_valid,
        output instruction,
        input  inst_legal,
        input  inst_class
    );

    modport slave (
        input  inst_valid,
        input  instruction,
        output inst_legal,
        output inst_class
    );
endinterface

// File: rtl/qed_inst_filter.sv
// rtl/qed_inst_filter.sv - stateful RV32I legality filter for SQED runs
module qed_inst_filter #(
    parameter int          REG_LIMIT  = 16,
    parameter int          MEM_WINDOW = 64,
    parameter logic [11:0] PRE_MASK   = 12'h803,
    parameter logic [11:0] POST_MASK  = 12'hFFF,
    parameter int          MAX_PRE_TC = 255,
    parameter int          STORE_GAP  = 2,
    parameter int          CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    qed_inst_filter_if.slave   bus,
    input  logic               sif_commit,
    output logic [1:0]         phase,
    output logic [CNT_W-1:0]   pre_count,
    output logic               violation
);
    localparam logic [1:0]  PH_PRE    = 2'd0;
    localparam logic [1:0]  PH_LOCKED = 2'd1;
    localparam logic [1:0]  PH_POST   = 2'd2;
    localparam logic [5:0]  REG_LIM   = 6'(REG_LIMIT);
    localparam logic [12:0] MEM_LIM   = 13'(MEM_WINDOW);
    localparam int          GAP_W     = (STORE_GAP > 1) ? $clog2(STORE_GAP + 1) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] pre_count_q, pre_count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             violation_q, violation_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_ok, rs1_ok, rs2_ok;
    logic [11:0] cls;
    logic [11:0] mask;
    logic        lock_block, gap_block, legal, accept, counts;

    assign opcode = bus.instruction[6:0];
    assign rd     = bus.instruction[11:7];
    assign funct3 = bus.instruction[14:12];
    assign rs1    = bus.instruction[19:15];
    assign rs2    = bus.instruction[24:20];
    assign funct7 = bus.instruction[31:25];
    assign rd_ok  = {1'b0, rd}  < REG_LIM;
    assign rs1_ok = {1'b0, rs1} < REG_LIM;
    assign rs2_ok = {1'b0, rs2} < REG_LIM;

    // Memory offsets are treated as unsigned so negative immediates fall outside the window.
    always_comb begin
        cls = '0;
        unique case (opcode)
            7'b0110011: cls[0] = (funct7 == 7'b0000000 ||
                                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                                 && rs1_ok && rs2_ok && rd_ok;
            7'b0010011: cls[1] = (funct3 == 3'b001 ? funct7 == 7'b0000000 :
                                  funct3 == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) :
                                  1'b1) && rs1_ok && rd_ok;
            7'b0000011: cls[2] = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 && rs1 == 5'd0 && {1'b0, bus.instruction[31:20]} < MEM_LIM && rd_ok;
            7'b0100011: cls[3] = (funct3 inside {3'b000, 3'b001, 3'b010}) && rs1 == 5'd0
                                 && {1'b0, funct7, rd} < MEM_LIM && rs2_ok;
            7'b1100011: cls[4] = !(funct3 inside {3'b010, 3'b011}) && rs1_ok && rs2_ok;
            7'b1101111: cls[5] = rd == 5'd0;
            7'b1100111: cls[6] = funct3 == 3'b000 && rd == 5'd0 && rs1_ok;
            7'b0110111: cls[7] = rd_ok;
            7'b0010111: cls[8] = rd == 5'd0;
            7'b0001111: cls[9] = funct3 == 3'b000;
            7'b1110011: cls[10] = bus.instruction == 32'h0000_0073 || bus.instruction == 32'h0010_0073;
            7'b1111111: cls[11] = 1'b1;
            default:    cls = '0;
        endcase
    end

    always_comb begin
        mask       = (state_q == PH_POST || sif_commit) ? POST_MASK : PRE_MASK;
        lock_block = state_q == PH_LOCKED && !cls[11] && !sif_commit;
        gap_block  = cls[3] && gap_q != '0;
        legal      = |(cls & mask) && !lock_block && !gap_block;
        accept     = bus.inst_valid && legal;
        counts     = accept && !cls[11] && state_q == PH_PRE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_PRE;
            pre_count_q <= '0;
            gap_q       <= '0;
            violation_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_count_q <= pre_count_d;
            gap_q       <= gap_d;
            violation_q <= violation_d;
        end
    end

    // Commit outranks the budget lock when both happen in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PH_PRE: begin
                if (sif_commit)
                    state_d = PH_POST;
                else if (MAX_PRE_TC != 0 && counts && pre_count_q + 1'b1 == CNT_W'(MAX_PRE_TC))
                    state_d = PH_LOCKED;
            end
            PH_LOCKED: if (sif_commit) state_d = PH_POST;
            PH_POST:   state_d = PH_POST;
            default:   state_d = PH_PRE;
        endcase
    end

    always_comb begin
        pre_count_d = pre_count_q;
        if (counts && pre_count_q != '1)
            pre_count_d = pre_count_q + 1'b1;
        gap_d = gap_q;
        if (accept && cls[3])
            gap_d = GAP_W'(STORE_GAP);
        else if (gap_q != '0)
            gap_d = gap_q - 1'b1;
        violation_d = violation_q || (bus.inst_valid && !legal);
    end

    always_comb begin
        phase          = state_q;
        pre_count      = pre_count_q;
        violation      = violation_q;
        bus.inst_legal = legal;
        bus.inst_class = cls;
    end
endmodule
